// File: rtl/ras_ckpt_queue.sv
// Checkpoint queue behind the return address stack: saves {sp, top-two} per in-flight
// control-flow instruction and replays the saved snapshot on a mispredict flush.
module ras_ckpt_queue #(
  parameter int RAS_ADDRESS  = 3,
  parameter int XLEN         = 32,
  parameter int CKPT_ADDRESS = 3
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic                    alloc_valid,
  input  logic [RAS_ADDRESS-1:0]  sp_snap,
  input  logic [2*XLEN-1:0]       ras_snap,
  output logic                    alloc_ready,
  output logic [CKPT_ADDRESS-1:0] alloc_tag,
  input  logic                    commit_valid,
  input  logic                    flush_valid,
  input  logic [CKPT_ADDRESS-1:0] flush_tag,
  output logic                    restore_valid,
  output logic [RAS_ADDRESS-1:0]  restore_sp,
  output logic [2*XLEN-1:0]       restore_top,
  output logic [CKPT_ADDRESS:0]   count,
  output logic                    empty,
  output logic                    full
);

  localparam int CKPT_LEN = 1 << CKPT_ADDRESS;
  localparam int ENTRY_W  = RAS_ADDRESS + 2*XLEN;
  localparam logic [CKPT_ADDRESS:0] PTR_ONE = 1;

  logic [CKPT_ADDRESS:0]   head, tail, flush_ptr;
  logic [CKPT_ADDRESS-1:0] head_idx, tail_idx, flush_off;
  logic [ENTRY_W-1:0]      mem [CKPT_LEN];
  logic                    flush_hit, alloc_fire, commit_fire;

  assign head_idx    = head[CKPT_ADDRESS-1:0];
  assign tail_idx    = tail[CKPT_ADDRESS-1:0];
  assign count       = tail - head;
  assign empty       = (head == tail);
  assign full        = (head_idx == tail_idx) && (head[CKPT_ADDRESS] != tail[CKPT_ADDRESS]);
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;

  // Age of the flushed entry relative to head; it is live only if younger than tail.
  assign flush_off   = flush_tag - head_idx;
  assign flush_hit   = flush_valid && ({1'b0, flush_off} < count);
  assign flush_ptr   = head + {1'b0, flush_off};
  assign alloc_fire  = alloc_valid && !full && !flush_valid;
  // Flushing the oldest entry empties the queue, so a same-cycle commit has nothing to retire.
  assign commit_fire = commit_valid && !empty && !(flush_hit && (flush_off == '0));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      head          <= '0;
      tail          <= '0;
      restore_valid <= 1'b0;
      restore_sp    <= '0;
      restore_top   <= '0;
    end else begin
      restore_valid <= flush_hit;
      if (commit_fire)
        head <= head + PTR_ONE;
      if (flush_hit) begin
        tail                      <= flush_ptr;
        {restore_sp, restore_top} <= mem[flush_tag];
      end else if (alloc_fire) begin
        tail <= tail + PTR_ONE;
      end
    end
  end

  // Snapshot storage is deliberately not reset; only live entries are ever read.
  always_ff @(posedge CLK) begin
    if (alloc_fire)
      mem[tail_idx] <= {sp_snap, ras_snap};
  end

endmodule

// File: tb/tb_ras_ckpt_queue.sv
// Self-checking bench for ras_ckpt_queue: a queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_ras_ckpt_queue;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [2:0]  sp_snap = '0;
  logic [63:0] ras_snap = '0;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        commit_valid = 1'b0;
  logic        flush_valid = 1'b0;
  logic [2:0]  flush_tag = '0;
  logic        restore_valid;
  logic [2:0]  restore_sp;
  logic [63:0] restore_top;
  logic [3:0]  count;
  logic        empty, full;

  int passed = 0;
  int total  = 0;
  bit checking = 0;

  ras_ckpt_queue dut (
    .CLK(CLK), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .sp_snap(sp_snap), .ras_snap(ras_snap),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .commit_valid(commit_valid), .flush_valid(flush_valid), .flush_tag(flush_tag),
    .restore_valid(restore_valid), .restore_sp(restore_sp), .restore_top(restore_top),
    .count(count), .empty(empty), .full(full)
  );

  always #5 CLK = ~CLK;

  // Reference model: live entries oldest-first in a queue, head as an ever-growing index.
  logic [66:0] m_q[$];
  int          m_head = 0;
  bit          m_rv = 0;
  logic [2:0]  m_rsp = '0;
  logic [63:0] m_rtop = '0;
  int          m_cnt, m_hidx, m_off;
  bit          m_fhit, m_cacc, m_aacc;

  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_head = 0;
      m_rv   = 0;
      m_rsp  = '0;
      m_rtop = '0;
    end else begin
      m_cnt  = m_q.size();
      m_hidx = m_head % 8;
      m_off  = (int'(flush_tag) - m_hidx + 8) % 8;
      m_fhit = flush_valid && (m_off < m_cnt);
      m_cacc = commit_valid && (m_cnt > 0);
      m_aacc = alloc_valid && (m_cnt < 8) && !flush_valid;
      m_rv   = m_fhit;
      if (m_fhit) begin
        {m_rsp, m_rtop} = m_q[m_off];
        while (m_q.size() > m_off) void'(m_q.pop_back());
        if (m_off == 0) m_cacc = 0;
      end
      if (m_cacc) begin
        void'(m_q.pop_front());
        m_head++;
      end
      if (m_aacc) m_q.push_back({sp_snap, ras_snap});
    end
  end

  task automatic check_val(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Every cycle, away from the rising edge, compare all outputs to the model.
  always @(negedge CLK) begin
    if (checking) begin
      check_val("model_count", count, m_q.size());
      check_val("model_empty", empty, m_q.size() == 0);
      check_val("model_full", full, m_q.size() == 8);
      check_val("model_alloc_ready", alloc_ready, m_q.size() != 8);
      check_val("model_alloc_tag", alloc_tag, (m_head + m_q.size()) % 8);
      check_val("model_restore_valid", restore_valid, m_rv);
      check_val("model_restore_sp", restore_sp, m_rsp);
      check_val("model_restore_top", restore_top, m_rtop);
    end
  end

  // One cycle of stimulus; returns just after the edge with all strobes cleared.
  task automatic apply_stimulus(bit a, bit c, bit f, logic [2:0] ft, int idx);
    logic [31:0] hi, lo;
    @(negedge CLK);
    #1;
    hi = 32'h100 + idx;
    lo = 32'h200 + idx;
    alloc_valid  = a;
    commit_valid = c;
    flush_valid  = f;
    flush_tag    = ft;
    sp_snap      = idx[2:0];
    ras_snap     = {hi, lo};
    @(posedge CLK);
    #1;
    alloc_valid  = 1'b0;
    commit_valid = 1'b0;
    flush_valid  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    checking = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1 reset_n = 1'b1;

    // Fill: tags 0..7, then a dropped ninth allocation
    for (int i = 0; i < 8; i++) begin
      check_val("fill_tag", alloc_tag, i);
      apply_stimulus(1, 0, 0, 3'd0, i);
    end
    check_val("fill_full", full, 1);
    check_val("fill_ready", alloc_ready, 0);
    apply_stimulus(1, 0, 0, 3'd0, 8);
    check_val("fill_drop_count", count, 8);

    // Reset arriving right after a valid flush drops the pending restore
    apply_stimulus(0, 0, 1, 3'd2, 0);
    check_val("pre_reset_rv", restore_valid, 1);
    reset_n = 1'b0;
    #1;
    check_val("reset_rv", restore_valid, 0);
    check_val("reset_count", count, 0);
    check_val("reset_empty", empty, 1);
    check_val("reset_tag", alloc_tag, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1 reset_n = 1'b1;

    // Flush in the middle of six entries
    for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0, 3'd0, i);
    apply_stimulus(0, 0, 1, 3'd3, 0);
    check_val("mid_rv", restore_valid, 1);
    check_val("mid_sp", restore_sp, 3);
    check_val("mid_top", restore_top, {32'h103, 32'h203});
    check_val("mid_count", count, 3);
    check_val("mid_tag", alloc_tag, 3);
    apply_stimulus(0, 0, 0, 3'd0, 0);
    check_val("mid_rv_drop", restore_valid, 0);
    check_val("mid_sp_hold", restore_sp, 3);

    // Wrap-around
    do_reset();
    for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0, 3'd0, i);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 1, 0, 3'd0, 0);
    for (int i = 6; i < 10; i++) begin
      check_val("wrap_tag", alloc_tag, i % 8);
      apply_stimulus(1, 0, 0, 3'd0, i);
    end
    check_val("wrap_count", count, 4);
    apply_stimulus(0, 0, 1, 3'd0, 0);
    check_val("wrap_rv", restore_valid, 1);
    check_val("wrap_sp", restore_sp, 0);
    check_val("wrap_top", restore_top, {32'h108, 32'h208});
    check_val("wrap_count_after", count, 2);

    // Simultaneous commit and flush of the head entry
    do_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 3'd0, i);
    apply_stimulus(0, 1, 0, 3'd0, 0);
    apply_stimulus(0, 1, 0, 3'd0, 0);
    check_val("sim_pre_count", count, 3);
    apply_stimulus(0, 1, 1, 3'd2, 0);
    check_val("sim_empty", empty, 1);
    check_val("sim_rv", restore_valid, 1);
    check_val("sim_sp", restore_sp, 2);
    check_val("sim_top", restore_top, {32'h102, 32'h202});
    apply_stimulus(1, 1, 1, 3'd5, 11);
    check_val("sim_oow_rv", restore_valid, 0);
    check_val("sim_oow_count", count, 0);

    // Flush with commit on a non-head entry, then commit+alloc together
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0, 3'd0, 20 + i);
    apply_stimulus(0, 1, 1, 3'd4, 0);
    check_val("fc_count", count, 1);
    check_val("fc_sp", restore_sp, (22 % 8));
    apply_stimulus(1, 1, 0, 3'd0, 30);
    check_val("ca_count", count, 1);

    // Invalid operations on an empty queue
    do_reset();
    apply_stimulus(0, 1, 0, 3'd0, 0);
    apply_stimulus(0, 0, 1, 3'd0, 0);
    check_val("inv_count", count, 0);
    check_val("inv_rv", restore_valid, 0);
    check_val("inv_tag", alloc_tag, 0);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    checking = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
